uart_rx: RTL and testbench

- Serial UART receiver: 8 data bits, no parity, 1 stop bit, LSB first.
- Sits directly downstream of uart_tx; in loopback benches it consumes uart_tx's txd and in the design it consumes the host RX pin.
- Recovers bytes by mid-bit sampling driven by a per-bit clock counter.
- Presents each good byte as a one-cycle valid pulse; flags bad stop bits.

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_2ff.sv | 23 ++
 rtl/uart_rx.sv | 128 ++++++++++++
 tb/tb_uart_rx.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and the receiver state type, common to uart_tx and uart_rx.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 104;
  localparam int unsigned UART_DATA_BITS       = 8;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous input.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle valid pulse per good byte,
// one-cycle frame_err pulse on a low stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err
);

  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(UART_DATA_BITS - 1);

  rx_state_t                  state;
  logic                       rxd_s;
  logic [CNT_W-1:0]           clk_cnt;
  logic [2:0]                 bit_idx;
  logic [UART_DATA_BITS-1:0]  shift_reg;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxd_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RX_IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      rx_busy   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;

      unique case (state)
        RX_IDLE: begin
          clk_cnt <= '0;
          if (!rxd_s) begin
            state   <= RX_START;
            rx_busy <= 1'b1;
          end
        end

        // A start bit that is high again at its midpoint is a glitch.
        RX_START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            if (!rxd_s) begin
              state <= RX_DATA;
            end else begin
              state   <= RX_IDLE;
              rx_busy <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        RX_DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt   <= '0;
            shift_reg <= {rxd_s, shift_reg[UART_DATA_BITS-1:1]};
            if (bit_idx == IDX_LAST) begin
              state <= RX_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        // Leaving at mid-stop-bit lets an immediately following start bit resync.
        RX_STOP: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            if (rxd_s) begin
              rx_byte  <= shift_reg;
              rx_valid <= 1'b1;
              state    <= RX_IDLE;
              rx_busy  <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= RX_WAIT_HIGH;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        // A break or stuck-low line must not decode as a stream of 0x00 frames.
        RX_WAIT_HIGH: begin
          clk_cnt <= '0;
          if (rxd_s) begin
            state   <= RX_IDLE;
            rx_busy <= 1'b0;
          end
        end

        default: begin
          state   <= RX_IDLE;
          clk_cnt <= '0;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a behavioural serial transmitter drives rxd,
// a monitor logs output pulses, and per-scenario tasks compare against expectations.
module tb_uart_rx;

  localparam int C    = 104;
  localparam int HALF = C / 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] got_b[$];
  int         got_t[$];
  int         err_cnt  = 0;
  int         both_cnt = 0;
  logic [7:0] last_good = 8'h00;
  int         t_fall;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .rx_busy   (rx_busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      got_b.push_back(rx_byte);
      got_t.push_back(cyc);
    end
    if (frame_err) err_cnt++;
    if (rx_valid && frame_err) both_cnt++;
  end

  task automatic clear_log();
    got_b.delete();
    got_t.delete();
    err_cnt  = 0;
    both_cnt = 0;
  endtask

  task automatic hold(input logic v, input int n);
    rxd = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    t_fall = cyc;
    hold(1'b0, C);
    for (int unsigned i = 0; i < 8; i++) hold(b[i], C);
    hold(stop, C);
    rxd = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rx_byte, rx_valid, rx_busy, frame_err} !== 11'h0) begin
      errors++;
      $display("FAIL reset_outputs: got byte=%h v=%b b=%b e=%b, want all 0",
               rx_byte, rx_valid, rx_busy, frame_err);
    end
    rst = 1'b0;
    hold(1'b1, 10);
  endtask

  task automatic test_loopback_42();
    clear_log();
    send_frame(8'h42, 1'b1);
    last_good = 8'h42;
    hold(1'b1, 20);
    checks++;
    if (got_b.size() != 1 || got_b[0] !== 8'h42) begin
      errors++;
      $display("FAIL loopback_42: got %0d pulses first=%h, want 1 pulse 42",
               got_b.size(), (got_b.size() > 0) ? got_b[0] : 8'hxx);
    end
    checks++;
    if (err_cnt != 0) begin
      errors++;
      $display("FAIL loopback_42_err: got %0d frame_err, want 0", err_cnt);
    end
    checks++;
    if (rx_busy !== 1'b0) begin
      errors++;
      $display("FAIL loopback_42_busy: got %b, want 0", rx_busy);
    end
  endtask

  task automatic test_back_to_back();
    int d;
    clear_log();
    send_frame(8'h42, 1'b1);
    send_frame(8'h41, 1'b1);
    last_good = 8'h41;
    hold(1'b1, 20);
    checks++;
    if (got_b.size() != 2 || got_b[0] !== 8'h42 || got_b[1] !== 8'h41) begin
      errors++;
      $display("FAIL back_to_back_bytes: got %0d pulses, want 42 then 41", got_b.size());
    end else begin
      d = got_t[1] - got_t[0];
      checks++;
      if (d < C * 10 - 1 || d > C * 10 + 1) begin
        errors++;
        $display("FAIL back_to_back_spacing: got %0d clocks, want %0d +-1", d, C * 10);
      end
    end
  endtask

  task automatic test_glitch();
    int busy_cnt = 0;
    clear_log();
    for (int i = 0; i < 250; i++) begin
      rxd = (i < 20) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (rx_busy) busy_cnt++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (busy_cnt < 1 || busy_cnt > HALF + 2) begin
      errors++;
      $display("FAIL glitch_busy: got %0d busy clocks, want 1..%0d", busy_cnt, HALF + 2);
    end
    checks++;
    if (got_b.size() != 0 || err_cnt != 0 || rx_busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_pulses: got valid=%0d err=%0d busy=%b, want 0 0 0",
               got_b.size(), err_cnt, rx_busy);
    end
  endtask

  task automatic test_frame_err();
    clear_log();
    send_frame(8'h55, 1'b0);
    hold(1'b0, 300);
    hold(1'b1, 2 * C);
    checks++;
    if (err_cnt != 1 || got_b.size() != 0) begin
      errors++;
      $display("FAIL frame_err_pulse: got err=%0d valid=%0d, want 1 0", err_cnt, got_b.size());
    end
    checks++;
    if (rx_byte !== last_good) begin
      errors++;
      $display("FAIL frame_err_hold: got rx_byte=%h, want %h", rx_byte, last_good);
    end
    send_frame(8'hA5, 1'b1);
    last_good = 8'hA5;
    hold(1'b1, 20);
    checks++;
    if (got_b.size() != 1 || got_b[0] !== 8'hA5 || err_cnt != 1) begin
      errors++;
      $display("FAIL frame_err_recover: got %0d pulses err=%0d, want one A5 and err 1",
               got_b.size(), err_cnt);
    end
  endtask

  task automatic test_latency();
    int d;
    clear_log();
    send_frame(8'h00, 1'b1);
    last_good = 8'h00;
    hold(1'b1, 20);
    checks++;
    if (got_b.size() != 1 || got_b[0] !== 8'h00) begin
      errors++;
      $display("FAIL latency_byte: got %0d pulses, want one 00", got_b.size());
    end else begin
      // Counted as rising edges from the rxd change up to the edge that raises rx_valid.
      d = got_t[0] - t_fall;
      checks++;
      if (d < 2 + HALF + 9 * C - 1 || d > 2 + HALF + 9 * C + 1) begin
        errors++;
        $display("FAIL latency: got %0d clocks, want %0d +-1", d, 2 + HALF + 9 * C);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_log();
    hold(1'b0, C);
    hold(1'b1, 3 * C + C / 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_good = 8'h00;
    checks++;
    if ({rx_byte, rx_valid, rx_busy, frame_err} !== 11'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got byte=%h v=%b b=%b e=%b, want all 0",
               rx_byte, rx_valid, rx_busy, frame_err);
    end
    hold(1'b1, 6 * C);
    checks++;
    if (got_b.size() != 0 || err_cnt != 0) begin
      errors++;
      $display("FAIL reset_mid_abort: got valid=%0d err=%0d, want 0 0", got_b.size(), err_cnt);
    end
    send_frame(8'h3C, 1'b1);
    last_good = 8'h3C;
    hold(1'b1, 20);
    checks++;
    if (got_b.size() != 1 || got_b[0] !== 8'h3C || err_cnt != 0) begin
      errors++;
      $display("FAIL reset_mid_next: got %0d pulses err=%0d, want one 3C", got_b.size(), err_cnt);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    clear_log();
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_frame(b, 1'b1);
      last_good = b;
      hold(1'b1, $urandom_range(0, 50));
    end
    hold(1'b1, 20);
    checks++;
    if (got_b.size() != exp_q.size()) begin
      errors++;
      $display("FAIL random_count: got %0d bytes, want %0d", got_b.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_b[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL random_byte[%0d]: got %h, want %h", i, got_b[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (err_cnt != 0 || rx_byte !== last_good) begin
      errors++;
      $display("FAIL random_tail: got err=%0d rx_byte=%h, want 0 %h", err_cnt, rx_byte, last_good);
    end
  endtask

  task automatic test_exclusive_pulses();
    checks++;
    if (both_cnt != 0) begin
      errors++;
      $display("FAIL exclusive_pulses: got %0d overlapping cycles, want 0", both_cnt);
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_loopback_42();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_latency();
    test_reset_mid_frame();
    test_random();
    test_exclusive_pulses();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
